// File: rtl/alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_sequencer
// Description : Four-entry register file and instruction sequencer feeding an
//               external combinational adder. Accepts NOP/LDI/ADD/OUT over a
//               valid/ready handshake, drives registered A/B operands, writes
//               the adder SUM back and exports values on a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_sequencer #(
    parameter int NREG = 4,
    parameter int W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [1:0]              instr_op,
    input  logic [$clog2(NREG)-1:0] instr_rd,
    input  logic [$clog2(NREG)-1:0] instr_rs1,
    input  logic [$clog2(NREG)-1:0] instr_rs2,
    input  logic [W-1:0]            instr_imm,
    output logic [W-1:0]            A,
    output logic [W-1:0]            B,
    input  logic [W-1:0]            SUM,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic                    carry_flag,
    output logic                    busy
);

    localparam int         c_IW     = $clog2(NREG);
    localparam logic [1:0] c_OP_NOP = 2'b00;
    localparam logic [1:0] c_OP_LDI = 2'b01;
    localparam logic [1:0] c_OP_ADD = 2'b10;
    localparam logic [1:0] c_OP_OUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_regs [NREG];
    logic [c_IW-1:0]   r_rd;
    logic [c_IW-1:0]   r_rs1;
    logic [c_IW-1:0]   r_rs2;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_out_data;
    logic              r_out_valid;
    logic              r_carry;
    logic              w_accept;

    // Ready is suppressed during reset so nothing is accepted on a reset edge.
    assign instr_ready = (r_state == S_IDLE) && !rst;
    assign busy        = (r_state != S_IDLE);
    assign w_accept    = instr_valid && instr_ready;
    assign A           = r_a;
    assign B           = r_b;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign carry_flag  = r_carry;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: only an accepted ADD leaves IDLE; READ and EXEC are one cycle each.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && (instr_op == c_OP_ADD)) w_next = S_READ;
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: register file, latched ADD indices, operands, output strobe and carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept) begin
                case (instr_op)
                    c_OP_LDI: r_regs[instr_rd] <= instr_imm;
                    c_OP_OUT: begin
                        r_out_data  <= r_regs[instr_rs1];
                        r_out_valid <= 1'b1;
                    end
                    c_OP_ADD: begin
                        // Fields may change after accept, so the indices are held here.
                        r_rd  <= instr_rd;
                        r_rs1 <= instr_rs1;
                        r_rs2 <= instr_rs2;
                    end
                    c_OP_NOP: ;
                    default:  ;
                endcase
            end
            if (r_state == S_READ) begin
                r_a <= r_regs[r_rs1];
                r_b <= r_regs[r_rs2];
            end
            if (r_state == S_EXEC) begin
                // A wrapped unsigned sum is always smaller than either operand.
                r_regs[r_rd] <= SUM;
                r_carry      <= (SUM < r_a);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_sequencer
// Description : Self-checking bench for alu_operand_sequencer with a
//               behavioural 4-bit adder on SUM and an out_data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_sequencer;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LDI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_OUT = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_op = 2'b00;
    logic [1:0] instr_rd = 2'b00;
    logic [1:0] instr_rs1 = 2'b00;
    logic [1:0] instr_rs2 = 2'b00;
    logic [3:0] instr_imm = 4'h0;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] SUM;
    logic       out_valid;
    logic [3:0] out_data;
    logic       carry_flag;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];

    typedef struct {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] imm;
        logic [3:0] exp_out;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic       exp_c;
    } vec_t;

    vec_t tbl [$];

    alu_operand_sequencer #(.NREG(4), .W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm   (instr_imm),
        .A           (A),
        .B           (B),
        .SUM         (SUM),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .carry_flag  (carry_flag),
        .busy        (busy)
    );

    // Downstream adder: combinational, wraps modulo 16.
    assign SUM = A + B;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every out_valid cycle must match the oldest pending OUT.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected_pulse", 1, 0);
            end else begin
                check("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] op, input logic [1:0] rd,
                                input logic [1:0] rs1, input logic [1:0] rs2,
                                input logic [3:0] imm, input logic [3:0] eo,
                                input logic [3:0] ea, input logic [3:0] eb,
                                input logic ec);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.exp_out = eo; v.exp_a = ea; v.exp_b = eb; v.exp_c = ec;
        return v;
    endfunction

    // Called and returns just after a rising edge; accepted at the next edge.
    task automatic issue(input logic [1:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2,
                         input logic [3:0] imm, input logic [3:0] exp_out);
        int t = 0;
        while (!instr_ready && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!instr_ready) check("issue_timeout", 0, 1);
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        if (op == OP_OUT) exp_q.push_back(exp_out);
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b1;
        step();
        step();
        check("rst_ready", int'(instr_ready), 0);
        check("rst_A", int'(A), 0);
        check("rst_B", int'(B), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_carry", int'(carry_flag), 0);
        check("rst_busy", int'(busy), 0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(instr_ready), 1);
        for (int r = 0; r < 4; r++) issue(OP_OUT, 2'd0, 2'(r), 2'd0, 4'h0, 4'h0);

        // ---------------- table-driven program ----------------
        tbl.push_back(mk(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_ADD, 2'd3, 2'd1, 2'd2, 4'h0, 4'h0, 4'h3, 4'h4, 1'b0));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd3, 2'd0, 4'h0, 4'h7, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_LDI, 2'd0, 2'd0, 2'd0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0, 4'hF, 4'h1, 1'b1));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd2, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_NOP, 2'd3, 2'd3, 2'd3, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_ADD, 2'd3, 2'd1, 2'd1, 4'h0, 4'h0, 4'h1, 4'h1, 1'b0));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd3, 2'd0, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_ADD, 2'd1, 2'd1, 2'd1, 4'h0, 4'h0, 4'h5, 4'h5, 1'b0));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd1, 2'd0, 4'h0, 4'hA, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_ADD, 2'd1, 2'd1, 2'd1, 4'h0, 4'h0, 4'hA, 4'hA, 1'b1));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd1, 2'd0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd0, 2'd0, 4'h0, 4'hF, 4'h0, 4'h0, 1'b0));
        tbl.push_back(mk(OP_OUT, 2'd0, 2'd3, 2'd0, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0));

        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].exp_out);
            if (tbl[i].op == OP_ADD) begin
                // After edge N: READ. After N+1: EXEC with operands. After N+2: IDLE.
                check("add_ready_n1", int'(instr_ready), 0);
                check("add_busy_n1", int'(busy), 1);
                step();
                check("add_ready_n2", int'(instr_ready), 0);
                check("exec_A", int'(A), int'(tbl[i].exp_a));
                check("exec_B", int'(B), int'(tbl[i].exp_b));
                step();
                check("add_ready_n3", int'(instr_ready), 1);
                check("add_carry", int'(carry_flag), int'(tbl[i].exp_c));
                check("hold_A", int'(A), int'(tbl[i].exp_a));
            end
        end
        // carry_flag untouched by LDI/OUT/NOP since the last ADD set it.
        check("carry_sticky", int'(carry_flag), 1);

        // ---------------- held valid during ADD ----------------
        // Registers now: r0=F r1=4 r2=0 r3=2. ADD r2 = r0 + r1 = 3, carry 1.
        issue(OP_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0);
        instr_valid = 1'b1;
        instr_op = OP_LDI; instr_rd = 2'd3; instr_imm = 4'h1;
        step();
        check("hold_busy", int'(busy), 1);
        instr_op = OP_LDI; instr_rd = 2'd1; instr_imm = 4'h2;
        step();
        check("hold_ready_idle", int'(instr_ready), 1);
        instr_op = OP_LDI; instr_rd = 2'd0; instr_imm = 4'h9;
        step();
        instr_valid = 1'b0;
        check("hold_accepted_once", int'(busy), 0);
        check("hold_carry", int'(carry_flag), 1);
        issue(OP_OUT, 2'd0, 2'd3, 2'd0, 4'h0, 4'h2);
        issue(OP_OUT, 2'd0, 2'd1, 2'd0, 4'h0, 4'h4);
        check("b2b_out_valid", int'(out_valid), 1);
        issue(OP_OUT, 2'd0, 2'd0, 2'd0, 4'h0, 4'h9);
        issue(OP_OUT, 2'd0, 2'd2, 2'd0, 4'h0, 4'h3);
        step();
        check("out_pulse_ends", int'(out_valid), 0);

        // ---------------- reset mid-ADD ----------------
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 4'h3, 4'h0);
        issue(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h4, 4'h0);
        issue(OP_ADD, 2'd2, 2'd0, 2'd1, 4'h0, 4'h0);
        step();
        check("mid_in_exec", int'(busy), 1);
        rst = 1'b1;
        step();
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_carry", int'(carry_flag), 0);
        check("mid_rst_ready", int'(instr_ready), 0);
        rst = 1'b0;
        #1;
        check("mid_ready_after", int'(instr_ready), 1);
        issue(OP_OUT, 2'd0, 2'd2, 2'd0, 4'h0, 4'h0);
        issue(OP_LDI, 2'd0, 2'd0, 2'd0, 4'h2, 4'h0);
        issue(OP_ADD, 2'd3, 2'd0, 2'd0, 4'h0, 4'h0);
        step();
        check("post_rst_A", int'(A), 2);
        step();
        issue(OP_OUT, 2'd0, 2'd3, 2'd0, 4'h0, 4'h4);

        step();
        step();
        check("out_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
